// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for the 8-bit two-accumulator core.
// It owns accumulators A/B and carry flags CA/CB, and accepts one decoded
// instruction at a time. ALU ops are steered to the combinational ALU,
// and the result and carry are captured on the way out of EXEC.
// Loads, stores, JMP and branches are resolved here without the ALU.
//
// Handshake: an instruction transfers on a rising edge where iInstValid and
// oInstReady are both high. oInstReady is high only in IDLE, so the
// controller ignores iInstValid while a transfer is in flight. Decode may
// hold iInstValid high; the next instruction transfers on the first edge
// where the controller is back in IDLE.
//
// Opcode map (shared with decode):
//   00 LDA   01 LDB   02 LDCA  03 LDCB  04 STA   05 STB
//   06 ADDA  07 ADDB  08 ADDCA 09 ADDCB 0A SUBA  0B SUBB
//   0C SUBCA 0D SUBCB 0E ANDA  0F ANDB  10 ANDCA 11 ANDCB
//   12 ORA   13 ORB   14 ORCA  15 ORCB  16 ASLA  17 ASRA
//   18 JMP   19 BAEQ  1A BANE  1B BACS  1C BACC  1D BAMI  1E BAPL
//   1F BBEQ  20 BBNE  21 BBCS  22 BBCC  23 BBMI  24 BBPL
module alu_exec_ctrl #(
  parameter int               DATA_W   = 8,
  parameter int               OPC_W    = 6,
  parameter logic [OPC_W-1:0] IDLE_SEL = 6'h3F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iInstValid,
  output logic              oInstReady,
  input  logic [OPC_W-1:0]  iOpcode,
  input  logic [DATA_W-1:0] iOperand,
  output logic [DATA_W-1:0] oAluOper1,
  output logic [DATA_W-1:0] oAluOper2,
  output logic [OPC_W-1:0]  oAluInstSel,
  input  logic [DATA_W-1:0] iAluData,
  input  logic              iAluBCA,
  input  logic              iAluBCB,
  output logic [DATA_W-1:0] oAccA,
  output logic [DATA_W-1:0] oAccB,
  output logic              oCarryA,
  output logic              oCarryB,
  output logic              oDone,
  output logic              oBranchTaken,
  output logic [DATA_W-1:0] oBranchTarget,
  output logic              oStoreEn,
  output logic [DATA_W-1:0] oStoreData,
  output logic              oIllegal,
  // Debug view of the sequencer: 0 = IDLE, 1 = EXEC, 2 = WB
  output logic [1:0]        oDbgState
);

  localparam logic [OPC_W-1:0] OP_LDA   = 6'h00, OP_LDB   = 6'h01;
  localparam logic [OPC_W-1:0] OP_LDCA  = 6'h02, OP_LDCB  = 6'h03;
  localparam logic [OPC_W-1:0] OP_STA   = 6'h04, OP_STB   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDA  = 6'h06, OP_ADDB  = 6'h07;
  localparam logic [OPC_W-1:0] OP_ADDCA = 6'h08, OP_ADDCB = 6'h09;
  localparam logic [OPC_W-1:0] OP_SUBA  = 6'h0A, OP_SUBB  = 6'h0B;
  localparam logic [OPC_W-1:0] OP_SUBCA = 6'h0C, OP_SUBCB = 6'h0D;
  localparam logic [OPC_W-1:0] OP_ANDA  = 6'h0E, OP_ANDB  = 6'h0F;
  localparam logic [OPC_W-1:0] OP_ANDCA = 6'h10, OP_ANDCB = 6'h11;
  localparam logic [OPC_W-1:0] OP_ORA   = 6'h12, OP_ORB   = 6'h13;
  localparam logic [OPC_W-1:0] OP_ORCA  = 6'h14, OP_ORCB  = 6'h15;
  localparam logic [OPC_W-1:0] OP_ASLA  = 6'h16, OP_ASRA  = 6'h17;
  localparam logic [OPC_W-1:0] OP_JMP   = 6'h18;
  localparam logic [OPC_W-1:0] OP_BAEQ  = 6'h19, OP_BANE  = 6'h1A;
  localparam logic [OPC_W-1:0] OP_BACS  = 6'h1B, OP_BACC  = 6'h1C;
  localparam logic [OPC_W-1:0] OP_BAMI  = 6'h1D, OP_BAPL  = 6'h1E;
  localparam logic [OPC_W-1:0] OP_BBEQ  = 6'h1F, OP_BBNE  = 6'h20;
  localparam logic [OPC_W-1:0] OP_BBCS  = 6'h21, OP_BBCC  = 6'h22;
  localparam logic [OPC_W-1:0] OP_BBMI  = 6'h23, OP_BBPL  = 6'h24;
  localparam logic [OPC_W-1:0] OP_LAST  = OP_BBPL;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            state;
  logic [OPC_W-1:0]  op_q;
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W-1:0] acc_a, acc_b;
  logic              ca, cb;
  logic              ready_q, done_q, taken_q, store_en_q, illegal_q;
  logic [DATA_W-1:0] store_data_q;
  logic [OPC_W-1:0]  alu_sel_q;
  logic [DATA_W-1:0] oper1_q, oper2_q;

  // Opcodes that go through the ALU (one EXEC cycle)
  function automatic logic is_alu(input logic [OPC_W-1:0] op);
    return (op >= OP_ADDA) && (op <= OP_ASRA);
  endfunction

  // ALU results that land in AccA
  function automatic logic wr_a(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA, OP_ANDA, OP_ANDCA,
      OP_ORA, OP_ORCA, OP_ASLA, OP_ASRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ALU results that land in AccB
  function automatic logic wr_b(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB, OP_ANDB, OP_ANDCB,
      OP_ORB, OP_ORCB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // B-with-constant ops put the constant on Oper1 so the ALU computes B op k
  function automatic logic oper1_is_k(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Ops that read AccB on Oper2; everything else sees the operand there
  function automatic logic oper2_is_b(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADDA, OP_ADDB, OP_SUBA, OP_SUBB, OP_ANDA, OP_ANDB, OP_ORA, OP_ORB,
      OP_ADDCB, OP_SUBCB, OP_ANDCB, OP_ORCB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Branch outcome from the accumulator/flag values before the instruction
  function automatic logic branch_cond(input logic [OPC_W-1:0] op,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b,
                                       input logic fa, input logic fb);
    case (op)
      OP_JMP:  return 1'b1;
      OP_BAEQ: return a == '0;
      OP_BANE: return a != '0;
      OP_BACS: return fa;
      OP_BACC: return !fa;
      OP_BAMI: return a[DATA_W-1];
      OP_BAPL: return !a[DATA_W-1];
      OP_BBEQ: return b == '0;
      OP_BBNE: return b != '0;
      OP_BBCS: return fb;
      OP_BBCC: return !fb;
      OP_BBMI: return b[DATA_W-1];
      OP_BBPL: return !b[DATA_W-1];
      default: return 1'b0;
    endcase
  endfunction

  // Sequencer: IDLE -> EXEC -> WB for ALU ops, IDLE -> WB for the rest
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      op_q         <= '0;
      opnd_q       <= '0;
      acc_a        <= '0;
      acc_b        <= '0;
      ca           <= 1'b0;
      cb           <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      taken_q      <= 1'b0;
      store_en_q   <= 1'b0;
      store_data_q <= '0;
      illegal_q    <= 1'b0;
      alu_sel_q    <= IDLE_SEL;
      oper1_q      <= '0;
      oper2_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          oper1_q <= acc_a;
          oper2_q <= opnd_q;
          if (iInstValid) begin
            op_q    <= iOpcode;
            opnd_q  <= iOperand;
            ready_q <= 1'b0;
            if (is_alu(iOpcode)) begin
              state     <= S_EXEC;
              alu_sel_q <= iOpcode;
              oper1_q   <= oper1_is_k(iOpcode) ? iOperand : acc_a;
              oper2_q   <= oper2_is_b(iOpcode) ? acc_b : iOperand;
            end else begin
              state        <= S_WB;
              done_q       <= 1'b1;
              taken_q      <= branch_cond(iOpcode, acc_a, acc_b, ca, cb);
              store_en_q   <= (iOpcode == OP_STA) || (iOpcode == OP_STB);
              store_data_q <= (iOpcode == OP_STB) ? acc_b : acc_a;
              illegal_q    <= iOpcode > OP_LAST;
              if ((iOpcode == OP_LDA) || (iOpcode == OP_LDCA)) acc_a <= iOperand;
              if ((iOpcode == OP_LDB) || (iOpcode == OP_LDCB)) acc_b <= iOperand;
            end
          end
        end
        S_EXEC: begin
          if (wr_a(op_q)) acc_a <= iAluData;
          if (wr_b(op_q)) acc_b <= iAluData;
          case (op_q)
            OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA: ca <= iAluBCA;
            OP_ADDB, OP_ADDCB:                    cb <= iAluBCB;
            // the ALU reports the B-side borrow on its A-side carry output
            OP_SUBB, OP_SUBCB:                    cb <= iAluBCA;
            default: ;
          endcase
          state     <= S_WB;
          done_q    <= 1'b1;
          alu_sel_q <= IDLE_SEL;
          oper1_q   <= acc_a;
          oper2_q   <= opnd_q;
        end
        S_WB: begin
          state      <= S_IDLE;
          done_q     <= 1'b0;
          taken_q    <= 1'b0;
          store_en_q <= 1'b0;
          illegal_q  <= 1'b0;
          ready_q    <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign oInstReady    = ready_q;
  assign oAluOper1     = oper1_q;
  assign oAluOper2     = oper2_q;
  assign oAluInstSel   = alu_sel_q;
  assign oAccA         = acc_a;
  assign oAccB         = acc_b;
  assign oCarryA       = ca;
  assign oCarryB       = cb;
  assign oDone         = done_q;
  assign oBranchTaken  = taken_q;
  assign oBranchTarget = opnd_q;
  assign oStoreEn      = store_en_q;
  assign oStoreData    = store_data_q;
  assign oIllegal      = illegal_q;
  assign oDbgState     = state;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a stand-in combinational ALU, an instruction-level
// reference model with a retire queue, a per-cycle compare process, and
// directed sequences with hand-computed expectations.
module tb_alu_exec_ctrl;

  localparam int W = 19; // {taken, store_en, illegal, store_data[7:0], target[7:0]}

  localparam logic [5:0] LDA = 6'h00, LDB = 6'h01, LDCA = 6'h02, LDCB = 6'h03;
  localparam logic [5:0] STA = 6'h04, STB = 6'h05;
  localparam logic [5:0] ADDA = 6'h06, ADDB = 6'h07, ADDCA = 6'h08, ADDCB = 6'h09;
  localparam logic [5:0] SUBA = 6'h0A, SUBB = 6'h0B, SUBCA = 6'h0C, SUBCB = 6'h0D;
  localparam logic [5:0] ANDA = 6'h0E, ANDB = 6'h0F, ANDCA = 6'h10, ANDCB = 6'h11;
  localparam logic [5:0] ORA = 6'h12, ORB = 6'h13, ORCA = 6'h14, ORCB = 6'h15;
  localparam logic [5:0] ASLA = 6'h16, ASRA = 6'h17, JMP = 6'h18;
  localparam logic [5:0] BAEQ = 6'h19, BANE = 6'h1A, BACS = 6'h1B, BACC = 6'h1C;
  localparam logic [5:0] BAMI = 6'h1D, BAPL = 6'h1E, BBEQ = 6'h1F, BBNE = 6'h20;
  localparam logic [5:0] BBCS = 6'h21, BBCC = 6'h22, BBMI = 6'h23, BBPL = 6'h24;

  // ---------------- clock / reset ----------------
  logic clk, reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       iInstValid;
  logic [5:0] iOpcode;
  logic [7:0] iOperand;
  logic       oInstReady;
  logic [7:0] oAluOper1, oAluOper2, iAluData;
  logic [5:0] oAluInstSel;
  logic       iAluBCA, iAluBCB;
  logic [7:0] oAccA, oAccB, oBranchTarget, oStoreData;
  logic       oCarryA, oCarryB, oDone, oBranchTaken, oStoreEn, oIllegal;
  logic [1:0] oDbgState;

  alu_exec_ctrl dut (
    .clk(clk), .reset(reset),
    .iInstValid(iInstValid), .oInstReady(oInstReady),
    .iOpcode(iOpcode), .iOperand(iOperand),
    .oAluOper1(oAluOper1), .oAluOper2(oAluOper2), .oAluInstSel(oAluInstSel),
    .iAluData(iAluData), .iAluBCA(iAluBCA), .iAluBCB(iAluBCB),
    .oAccA(oAccA), .oAccB(oAccB), .oCarryA(oCarryA), .oCarryB(oCarryB),
    .oDone(oDone), .oBranchTaken(oBranchTaken), .oBranchTarget(oBranchTarget),
    .oStoreEn(oStoreEn), .oStoreData(oStoreData), .oIllegal(oIllegal),
    .oDbgState(oDbgState)
  );

  // ---------------- stand-in ALU ----------------
  // The unused carry output carries the opposite value, and AND/OR/shift
  // drive carries that differ from what a flag-preserving controller keeps.
  logic [8:0] s9;
  always_comb begin
    s9 = '0; iAluData = '0; iAluBCA = 1'b0; iAluBCB = 1'b0;
    case (oAluInstSel)
      ADDA, ADDCA: begin s9 = {1'b0, oAluOper1} + {1'b0, oAluOper2};
        iAluData = s9[7:0]; iAluBCA = s9[8]; iAluBCB = ~s9[8]; end
      ADDB, ADDCB: begin s9 = {1'b0, oAluOper1} + {1'b0, oAluOper2};
        iAluData = s9[7:0]; iAluBCB = s9[8]; iAluBCA = ~s9[8]; end
      SUBA, SUBCA: begin iAluData = oAluOper1 - oAluOper2;
        iAluBCA = oAluOper1 < oAluOper2; iAluBCB = ~iAluBCA; end
      SUBB, SUBCB: begin iAluData = oAluOper2 - oAluOper1;
        iAluBCA = oAluOper2 < oAluOper1; iAluBCB = ~iAluBCA; end
      ANDA, ANDB, ANDCA, ANDCB: iAluData = oAluOper1 & oAluOper2;
      ORA, ORB, ORCA, ORCB:     iAluData = oAluOper1 | oAluOper2;
      ASLA: begin iAluData = {oAluOper1[6:0], 1'b0}; iAluBCA = oAluOper1[7]; iAluBCB = 1'b1; end
      ASRA: begin iAluData = {oAluOper1[7], oAluOper1[7:1]}; iAluBCA = oAluOper1[0]; iAluBCB = 1'b1; end
      default: ;
    endcase
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] a, b;
    logic       ca, cb, taken, st_en, ill, alu;
    logic [7:0] st_data, o1, o2;
  } res_t;

  function automatic res_t eval(input logic [5:0] op, input logic [7:0] k,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic ca, input logic cb);
    res_t r;
    logic [8:0] s;
    r = '0; r.a = a; r.b = b; r.ca = ca; r.cb = cb; r.o1 = a; r.o2 = k;
    s = '0;
    r.alu = (op >= 6'h06) && (op <= 6'h17);
    case (op)
      LDA, LDCA: r.a = k;
      LDB, LDCB: r.b = k;
      STA: begin r.st_en = 1'b1; r.st_data = a; end
      STB: begin r.st_en = 1'b1; r.st_data = b; end
      ADDA:  begin s = {1'b0, a} + {1'b0, b}; r.a = s[7:0]; r.ca = s[8]; r.o2 = b; end
      ADDB:  begin s = {1'b0, a} + {1'b0, b}; r.b = s[7:0]; r.cb = s[8]; r.o2 = b; end
      ADDCA: begin s = {1'b0, a} + {1'b0, k}; r.a = s[7:0]; r.ca = s[8]; end
      ADDCB: begin s = {1'b0, b} + {1'b0, k}; r.b = s[7:0]; r.cb = s[8]; r.o1 = k; r.o2 = b; end
      SUBA:  begin r.a = a - b; r.ca = a < b; r.o2 = b; end
      SUBB:  begin r.b = b - a; r.cb = b < a; r.o2 = b; end
      SUBCA: begin r.a = a - k; r.ca = a < k; end
      SUBCB: begin r.b = b - k; r.cb = b < k; r.o1 = k; r.o2 = b; end
      ANDA:  begin r.a = a & b; r.o2 = b; end
      ANDB:  begin r.b = a & b; r.o2 = b; end
      ANDCA: r.a = a & k;
      ANDCB: begin r.b = b & k; r.o1 = k; r.o2 = b; end
      ORA:   begin r.a = a | b; r.o2 = b; end
      ORB:   begin r.b = a | b; r.o2 = b; end
      ORCA:  r.a = a | k;
      ORCB:  begin r.b = b | k; r.o1 = k; r.o2 = b; end
      ASLA:  r.a = {a[6:0], 1'b0};
      ASRA:  r.a = {a[7], a[7:1]};
      JMP:   r.taken = 1'b1;
      BAEQ:  r.taken = (a == 8'h00);
      BANE:  r.taken = (a != 8'h00);
      BACS:  r.taken = ca;
      BACC:  r.taken = !ca;
      BAMI:  r.taken = a[7];
      BAPL:  r.taken = !a[7];
      BBEQ:  r.taken = (b == 8'h00);
      BBNE:  r.taken = (b != 8'h00);
      BBCS:  r.taken = cb;
      BBCC:  r.taken = !cb;
      BBMI:  r.taken = b[7];
      BBPL:  r.taken = !b[7];
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  logic [7:0] m_a, m_b, p_a, p_b, m_o1, m_o2;
  logic       m_ca, m_cb, p_ca, p_cb;
  logic [5:0] m_op;
  int         m_rem;      // cycles until the model is ready again
  int         acc_cnt;
  int         cyc;
  int         acc_q[$];   // cycle number of every accept edge
  logic [W-1:0] exp_q[$]; // expected retire record per accepted instruction
  res_t       nx;

  assign nx = eval(iOpcode, iOperand, m_a, m_b, m_ca, m_cb);

  initial begin cyc = 0; acc_cnt = 0; end
  always @(posedge clk) cyc <= cyc + 1;

  // Model: instruction-level state plus a cycle countdown to the next accept
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a <= '0; m_b <= '0; m_ca <= 1'b0; m_cb <= 1'b0; m_rem <= 0;
      exp_q.delete();
    end else if (m_rem == 0 && iInstValid) begin
      acc_cnt <= acc_cnt + 1;
      acc_q.push_back(cyc);
      exp_q.push_back({nx.taken, nx.st_en, nx.ill, nx.st_data, iOperand});
      m_op <= iOpcode; m_o1 <= nx.o1; m_o2 <= nx.o2;
      if (nx.alu) begin
        m_rem <= 2;
        p_a <= nx.a; p_b <= nx.b; p_ca <= nx.ca; p_cb <= nx.cb;
      end else begin
        m_rem <= 1;
        m_a <= nx.a; m_b <= nx.b;
      end
    end else if (m_rem == 2) begin
      m_a <= p_a; m_b <= p_b; m_ca <= p_ca; m_cb <= p_cb; m_rem <= 1;
    end else if (m_rem == 1) begin
      m_rem <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  int vec_cnt = 0, fail_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [W-1:0] e;
    chk("ready", {31'd0, oInstReady}, {31'd0, m_rem == 0});
    chk("done", {31'd0, oDone}, {31'd0, m_rem == 1});
    chk("dbg_state", {30'd0, oDbgState}, (m_rem == 2) ? 1 : (m_rem == 1) ? 2 : 0);
    chk("acc_a", {24'd0, oAccA}, {24'd0, m_a});
    chk("acc_b", {24'd0, oAccB}, {24'd0, m_b});
    chk("carry_a", {31'd0, oCarryA}, {31'd0, m_ca});
    chk("carry_b", {31'd0, oCarryB}, {31'd0, m_cb});
    if (m_rem == 2) begin
      chk("alu_sel", {26'd0, oAluInstSel}, {26'd0, m_op});
      chk("alu_oper1", {24'd0, oAluOper1}, {24'd0, m_o1});
      chk("alu_oper2", {24'd0, oAluOper2}, {24'd0, m_o2});
    end else begin
      chk("alu_sel_idle", {26'd0, oAluInstSel}, 32'h3F);
    end
    if (m_rem == 1) begin
      if (exp_q.size() == 0) begin
        chk("retire_queue_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("branch_taken", {31'd0, oBranchTaken}, {31'd0, e[18]});
        chk("store_en", {31'd0, oStoreEn}, {31'd0, e[17]});
        chk("illegal", {31'd0, oIllegal}, {31'd0, e[16]});
        if (e[17]) chk("store_data", {24'd0, oStoreData}, {24'd0, e[15:8]});
        if (e[18]) chk("branch_target", {24'd0, oBranchTarget}, {24'd0, e[7:0]});
      end
    end else begin
      chk("store_en_idle", {31'd0, oStoreEn}, 0);
      chk("illegal_idle", {31'd0, oIllegal}, 0);
    end
  endtask

  always @(negedge clk) if (!reset) check_cycle();

  // ---------------- driver tasks ----------------
  task automatic wait_acc(input int target);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (acc_cnt >= target) break;
    end
    if (acc_cnt < target) chk("accept_timeout", 0, 1);
  endtask

  task automatic send(input logic [5:0] op, input logic [7:0] k);
    int base;
    base = acc_cnt;
    iOpcode = op; iOperand = k; iInstValid = 1'b1;
    wait_acc(base + 1);
    iInstValid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      if (m_rem == 0) break;
      @(posedge clk); #1;
    end
    if (m_rem != 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic run(input logic [5:0] op, input logic [7:0] k);
    send(op, k);
    wait_idle();
  endtask

  typedef struct packed { logic [5:0] op; logic [7:0] k; } vec_t;
  vec_t tbl[25];

  // ---------------- directed sequences ----------------
  initial begin
    int n;
    reset = 1'b1; iInstValid = 1'b0; iOpcode = '0; iOperand = '0;
    #2;
    chk("rst_acc_a", {24'd0, oAccA}, 0);
    chk("rst_acc_b", {24'd0, oAccB}, 0);
    chk("rst_flags", {30'd0, oCarryA, oCarryB}, 0);
    chk("rst_ready", {31'd0, oInstReady}, 1);
    chk("rst_pulses", {28'd0, oDone, oStoreEn, oIllegal, oBranchTaken}, 0);
    chk("rst_sel", {26'd0, oAluInstSel}, 32'h3F);
    chk("rst_opers", {16'd0, oAluOper1, oAluOper2}, 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1: F0 + 20 into B
    run(LDCA, 8'hF0);
    run(LDCB, 8'h20);
    send(ADDB, 8'h00);
    @(negedge clk); chk("t1_done_n1", {31'd0, oDone}, 0);
    @(negedge clk); chk("t1_done_n2", {31'd0, oDone}, 1);
    wait_idle();
    chk("t1_acc_b", {24'd0, oAccB}, 32'h10);
    chk("t1_cb", {31'd0, oCarryB}, 1);
    chk("t1_ca", {31'd0, oCarryA}, 0);

    // 2: 05 - 06 borrows, then branch on CA
    run(LDCA, 8'h05);
    run(SUBCA, 8'h06);
    chk("t2_acc_a", {24'd0, oAccA}, 32'hFF);
    chk("t2_ca", {31'd0, oCarryA}, 1);
    send(BACS, 8'h40);
    @(negedge clk);
    chk("t2_taken", {31'd0, oBranchTaken}, 1);
    chk("t2_target", {24'd0, oBranchTarget}, 32'h40);
    wait_idle();

    // 3: zero tests and JMP
    run(LDCA, 8'h00);
    send(BAEQ, 8'h12); @(negedge clk); chk("t3_baeq", {31'd0, oBranchTaken}, 1); wait_idle();
    send(BANE, 8'h34); @(negedge clk); chk("t3_bane", {31'd0, oBranchTaken}, 0); wait_idle();
    send(JMP, 8'h33);  @(negedge clk); chk("t3_jmp", {31'd0, oBranchTaken}, 1); wait_idle();
    chk("t3_regs", {8'd0, oAccA, oAccB, 6'd0, oCarryA, oCarryB}, {8'd0, 8'h00, 8'h10, 6'd0, 2'b11});

    // 4: valid held high across ALU and non-ALU ops
    n = acc_cnt;
    iOpcode = ADDA; iOperand = 8'h00; iInstValid = 1'b1;
    wait_acc(n + 1);
    iOpcode = LDA; iOperand = 8'h77;
    wait_acc(n + 2);
    iOpcode = STA; iOperand = 8'h00;
    wait_acc(n + 3);
    iInstValid = 1'b0;
    wait_idle();
    n = acc_q.size();
    chk("t4_gap_alu", acc_q[n-2] - acc_q[n-3], 3);
    chk("t4_gap_nonalu", acc_q[n-1] - acc_q[n-2], 2);
    chk("t4_acc_a", {24'd0, oAccA}, 32'h77);

    // 5: store and illegal
    run(LDCB, 8'hA5);
    send(STB, 8'h00); @(negedge clk);
    chk("t5_store_en", {31'd0, oStoreEn}, 1);
    chk("t5_store_data", {24'd0, oStoreData}, 32'hA5);
    wait_idle();
    send(6'h30, 8'h99); @(negedge clk);
    chk("t5_illegal", {31'd0, oIllegal}, 1);
    wait_idle();
    chk("t5_regs", {16'd0, oAccA, oAccB}, {16'd0, 8'h77, 8'hA5});

    // broad ALU/branch coverage checked by the model
    tbl = '{'{LDCA, 8'h3C}, '{LDCB, 8'hC5}, '{SUBB, 8'h00}, '{SUBCB, 8'h07},
            '{ADDCB, 8'hF0}, '{ANDCB, 8'h0F}, '{ORCB, 8'h80}, '{ANDCA, 8'hF3},
            '{ORCA, 8'h01}, '{ASLA, 8'h00}, '{ASRA, 8'h00}, '{BBMI, 8'h50},
            '{BBPL, 8'h51}, '{BBCS, 8'h52}, '{BBCC, 8'h53}, '{BBEQ, 8'h54},
            '{BBNE, 8'h55}, '{BAMI, 8'h56}, '{BAPL, 8'h57}, '{BACC, 8'h58},
            '{ORA, 8'h00}, '{ANDB, 8'h00}, '{ORB, 8'h00}, '{SUBA, 8'h00},
            '{ADDCA, 8'h90}};
    for (int i = 0; i < 25; i++) run(tbl[i].op, tbl[i].k);

    // 6: reset during EXEC discards the instruction
    run(LDCA, 8'h80);
    run(LDCB, 8'h80);
    send(ADDA, 8'h00);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_accs", {16'd0, oAccA, oAccB}, 0);
    chk("t6_rst_flags", {30'd0, oCarryA, oCarryB}, 0);
    chk("t6_rst_ready_done", {30'd0, oInstReady, oDone}, 32'h2);
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t6_no_wb", {16'd0, oAccA, oAccB}, 0);
    run(LDCA, 8'hFF);
    run(ADDCA, 8'h01);
    chk("t6_ca_set", {23'd0, oCarryA, oAccA}, 32'h100);
    run(LDCB, 8'h0F);
    run(ANDA, 8'h00);
    chk("t6_anda", {23'd0, oCarryA, oAccA}, 32'h100);
    run(ORA, 8'h00);
    chk("t6_ora", {23'd0, oCarryA, oAccA}, 32'h10F);
    run(ADDCB, 8'hF1);
    run(ANDB, 8'h00);
    chk("t6_andb", {23'd0, oCarryB, oAccB}, 32'h100);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
